// File: rtl/jtdsp16_sio_rx.sv
// DSP16 SIO receiver: samples DI/ICK/ILD, assembles 8/16-bit words
// into the SDX input buffer and drives IBF/overrun status.
module jtdsp16_sio_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        ick,
  input  logic        ild,
  input  logic        di,
  input  logic        ilen,
  input  logic        msb_first,
  input  logic        sdx_rd,
  output logic [15:0] sdx_dout,
  output logic        ibf,
  output logic        ovr,
  output logic        busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] ick_q;
  logic [SYNC_STAGES-1:0] ild_q;
  logic [SYNC_STAGES-1:0] di_q;

  logic ick_s, ild_s, di_s;
  logic ick_d;
  logic rise, start, rd_ok;

  logic [15:0] sr, sr_nx;
  logic [4:0]  cnt, cnt_nx;
  logic        len8, len8_nx;
  logic        msbf, msbf_nx;

  logic        f_len8, f_msb;
  logic [15:0] base, shifted, word;
  logic [4:0]  cnt_inc, n_bits;
  logic        xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ick_q <= '0;
      ild_q <= '0;
      di_q  <= '0;
      ick_d <= 1'b0;
    end else begin
      ick_q <= {ick_q[SYNC_STAGES-2:0], ick};
      ild_q <= {ild_q[SYNC_STAGES-2:0], ild};
      di_q  <= {di_q[SYNC_STAGES-2:0], di};
      ick_d <= ick_s;
    end
  end

  assign ick_s = ick_q[SYNC_STAGES-1];
  assign ild_s = ild_q[SYNC_STAGES-1];
  assign di_s  = di_q[SYNC_STAGES-1];

  assign rise  = ick_s & ~ick_d;
  assign start = rise & ild_s;
  assign rd_ok = sdx_rd & cen;
  assign busy  = (state == SHIFT);

  // A frame start shifts into a cleared register with fresh settings
  always_comb begin
    f_len8  = start ? ilen : len8;
    f_msb   = start ? msb_first : msbf;
    base    = start ? 16'h0000 : sr;
    cnt_inc = start ? 5'd1 : cnt + 5'd1;
    n_bits  = f_len8 ? 5'd8 : 5'd16;
    if (f_msb)
      shifted = {base[14:0], di_s};
    else if (f_len8)
      shifted = {8'h00, di_s, base[7:1]};
    else
      shifted = {di_s, base[15:1]};
    word = f_len8 ? {8'h00, shifted[7:0]} : shifted;
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    len8_nx  = len8;
    msbf_nx  = msbf;
    xfer     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = SHIFT;
          sr_nx    = shifted;
          cnt_nx   = 5'd1;
          len8_nx  = ilen;
          msbf_nx  = msb_first;
        end
      end
      SHIFT: begin
        if (rise) begin
          sr_nx   = shifted;
          cnt_nx  = cnt_inc;
          len8_nx = f_len8;
          msbf_nx = f_msb;
          if (cnt_inc == n_bits) begin
            xfer     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      len8  <= 1'b0;
      msbf  <= 1'b0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
      len8  <= len8_nx;
      msbf  <= msbf_nx;
    end
  end

  // A same-cycle read cannot raise overrun; the new word wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdx_dout <= '0;
      ibf      <= 1'b0;
      ovr      <= 1'b0;
    end else if (xfer) begin
      sdx_dout <= word;
      ibf      <= 1'b1;
      if (!rd_ok)
        ovr <= ovr | ibf;
    end else if (rd_ok) begin
      ibf <= 1'b0;
      ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// Bench for jtdsp16_sio_rx: vector table, corner sequences and
// randomized frames against a word-level reference model.
module tb_jtdsp16_sio_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        ick;
  logic        ild;
  logic        di;
  logic        ilen;
  logic        msb_first;
  logic        sdx_rd;
  logic [15:0] sdx_dout;
  logic        ibf;
  logic        ovr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  jtdsp16_sio_rx #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .ick       (ick),
    .ild       (ild),
    .di        (di),
    .ilen      (ilen),
    .msb_first (msb_first),
    .sdx_rd    (sdx_rd),
    .sdx_dout  (sdx_dout),
    .ibf       (ibf),
    .ovr       (ovr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        len8;
    logic        msb;
    logic [15:0] data;
    bit          rd;
    logic [15:0] exp_dout;
    logic        exp_ibf;
    logic        exp_ovr;
  } vec_t;

  vec_t tbl[7];

  // model state for the random phase
  logic [15:0] m_dout;
  logic        m_ibf;
  logic        m_ovr;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic ld, input bit rd_end);
    @(negedge clk);
    ick = 1'b0;
    di  = b;
    ild = ld;
    repeat (4) @(negedge clk);
    ick = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (rd_end && k == 2) begin
        sdx_rd = 1'b1;
        cen    = 1'b1;
      end
      if (k == 3) begin
        sdx_rd = 1'b0;
        cen    = 1'b0;
      end
    end
  endtask

  task automatic send_word(input logic l8, input logic mf,
                           input logic [15:0] data, input bit rd_end,
                           input int flip_at);
    int n;
    int idx;
    n = l8 ? 8 : 16;
    ilen = l8;
    msb_first = mf;
    for (int i = 0; i < n; i++) begin
      idx = mf ? (n - 1 - i) : i;
      if (i == flip_at)
        ilen = ~ilen;
      send_bit(data[idx], i == 0, rd_end && (i == n - 1));
    end
    ilen = l8;
  endtask

  task automatic do_read(input logic c);
    @(negedge clk);
    sdx_rd = 1'b1;
    cen    = c;
    @(negedge clk);
    sdx_rd = 1'b0;
    cen    = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [15:0] d,
                         input logic i, input logic o, input logic b);
    chk({name, ".dout"}, sdx_dout, d);
    chk({name, ".ibf"}, {15'b0, ibf}, {15'b0, i});
    chk({name, ".ovr"}, {15'b0, ovr}, {15'b0, o});
    chk({name, ".busy"}, {15'b0, busy}, {15'b0, b});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ick = 1'b0;
    ild = 1'b0;
    di  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [15:0] pat;
    logic        l8, mf;
    int          r;

    rst = 1'b1; cen = 1'b0; ick = 1'b0; ild = 1'b0; di = 1'b0;
    ilen = 1'b0; msb_first = 1'b1; sdx_rd = 1'b0;

    tbl[0] = '{1'b0, 1'b1, 16'hA5C3, 1'b1, 16'hA5C3, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h003C, 1'b1, 16'h003C, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'h1111, 1'b0, 16'h1111, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 16'h2222, 1'b1, 16'h2222, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 16'h00F0, 1'b0, 16'h00F0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 16'h0081, 1'b1, 16'h0081, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 16'h1234, 1'b1, 16'h1234, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // latency of the final bit: update two clk edges after ick seen high
    ilen = 1'b0;
    msb_first = 1'b1;
    pat = 16'hA5C3;
    for (int i = 0; i < 15; i++)
      send_bit(pat[15 - i], i == 0, 1'b0);
    @(negedge clk);
    ick = 1'b0;
    di  = pat[0];
    ild = 1'b0;
    repeat (4) @(negedge clk);
    ick = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("lat.ibf_early", {15'b0, ibf}, 16'h0000);
    chk("lat.busy_early", {15'b0, busy}, 16'h0001);
    @(posedge clk);
    #1;
    chk("lat.ibf", {15'b0, ibf}, 16'h0001);
    chk("lat.busy", {15'b0, busy}, 16'h0000);
    chk("lat.dout", sdx_dout, 16'hA5C3);
    repeat (4) @(negedge clk);
    do_read(1'b1);
    chk("lat.rd_ibf", {15'b0, ibf}, 16'h0000);

    foreach (tbl[t]) begin
      send_word(tbl[t].len8, tbl[t].msb, tbl[t].data, 1'b0, -1);
      chk_out($sformatf("vec%0d", t), tbl[t].exp_dout, tbl[t].exp_ibf,
              tbl[t].exp_ovr, 1'b0);
      if (tbl[t].rd) begin
        do_read(1'b1);
        chk_out($sformatf("vec%0d.rd", t), tbl[t].exp_dout, 1'b0, 1'b0, 1'b0);
      end
    end

    // resync: ild mid-frame restarts the word
    do_read(1'b1);
    for (int i = 0; i < 5; i++)
      send_bit(1'(i & 1), i == 0, 1'b0);
    chk_out("resync.mid", 16'h1234, 1'b0, 1'b0, 1'b1);
    send_word(1'b0, 1'b1, 16'hBEEF, 1'b0, -1);
    chk_out("resync", 16'hBEEF, 1'b1, 1'b0, 1'b0);

    // read coinciding with the transfer of a second word
    do_read(1'b1);
    send_word(1'b0, 1'b1, 16'h1357, 1'b0, -1);
    chk_out("simul.w1", 16'h1357, 1'b1, 1'b0, 1'b0);
    send_word(1'b1, 1'b0, 16'h00C6, 1'b1, -1);
    chk_out("simul.w2", 16'h00C6, 1'b1, 1'b0, 1'b0);
    do_read(1'b0);
    chk_out("cen0_rd", 16'h00C6, 1'b1, 1'b0, 1'b0);
    do_read(1'b1);
    chk_out("cen1_rd", 16'h00C6, 1'b0, 1'b0, 1'b0);

    // async reset mid-frame, then a frame with ilen toggled inside it
    send_word(1'b0, 1'b1, 16'h4444, 1'b0, -1);
    for (int i = 0; i < 9; i++)
      send_bit(1'(~i & 1), i == 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    ick = 1'b0;
    #1;
    chk_out("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_word(1'b0, 1'b1, 16'h0F0F, 1'b0, 4);
    chk_out("rst_after", 16'h0F0F, 1'b1, 1'b0, 1'b0);

    // randomized frames against the word-level model
    do_reset();
    m_dout = 16'h0000;
    m_ibf  = 1'b0;
    m_ovr  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 2);
      if (r == 1) begin
        do_read(1'b1);
        m_ibf = 1'b0;
        m_ovr = 1'b0;
      end else if (r == 2) begin
        do_read(1'b0);
      end
      l8  = 1'($urandom_range(0, 1));
      mf  = 1'($urandom_range(0, 1));
      pat = 16'($urandom);
      send_word(l8, mf, pat, 1'b0, -1);
      if (m_ibf)
        m_ovr = 1'b1;
      m_ibf  = 1'b1;
      m_dout = l8 ? (pat & 16'h00FF) : pat;
      chk_out($sformatf("rnd%0d", n), m_dout, m_ibf, m_ovr, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
